// File: rtl/periph_bus_master_pkg.sv
// Shared definitions for the peripheral bus initiator: bus address map,
// FSM state encoding and the key-code edge detect helper.
package periph_bus_master_pkg;

  localparam logic [3:0] KEY_ADDR  = 4'h0;
  localparam logic [3:0] IDLE_ADDR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // A keypad code is queued only on a press edge: non-zero and different
  // from the code seen by the previous poll.
  function automatic logic key_is_new(input logic [7:0] code, input logic [7:0] last);
    return (code != 8'h00) && (code != last);
  endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Peripheral bus: 4-bit address, 32-bit write data, write strobe and the
// slave's registered 8-bit read data (valid one clock after the address).
//   master: drives address/din/writeEnable, receives dout
//   slave : the reverse
interface periph_bus_master_if;
  logic [3:0]  address;
  logic [31:0] din;
  logic        writeEnable;
  logic [7:0]  dout;

  modport master (output address, din, writeEnable, input dout);
  modport slave  (input address, din, writeEnable, output dout);
endinterface

// File: rtl/periph_bus_master_key_fifo.sv
// Show-ahead FIFO for keypad codes.
//   clk, rst        : clock, async active-high reset (empties the FIFO)
//   push, push_data : enqueue; accepted when not full or when popping this cycle
//   pop             : dequeue head; ignored when empty
//   full, empty     : occupancy flags
//   head            : oldest entry, valid while !empty
module periph_bus_master_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: runs CPU load/store requests as bus cycles,
// returns read data, and periodically polls the keypad, queuing new codes.
//   clk, rst                         : clock, async active-high reset
//   cpu_req/we/addr/wdata            : CPU request, held until cpu_ready
//   cpu_ready                        : request accepted this cycle
//   cpu_rvalid, cpu_rdata            : read completion pulse and held data
//   key_valid, key_data, key_pop     : show-ahead key-code queue
//   key_overflow, key_clear          : sticky drop flag and its clear
//   bus                              : peripheral bus (master side)
module periph_bus_master
  import periph_bus_master_pkg::*;
#(
  parameter int POLL_PERIOD    = 1000,
  parameter int KEY_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic        key_valid,
  output logic [7:0]  key_data,
  input  logic        key_pop,
  output logic        key_overflow,
  input  logic        key_clear,
  periph_bus_master_if.master bus
);

  localparam int CW = $clog2(POLL_PERIOD);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    addr_nxt;
  logic [31:0]   din_nxt;
  logic          we_nxt;
  logic          sel_cpu;
  logic          sel_poll;
  logic          capture;
  logic          owner_cpu;
  logic          last_cpu;
  logic [CW-1:0] poll_cnt;
  logic          poll_wrap;
  logic          poll_pend;
  logic [7:0]    last_key;
  logic          poll_cap;
  logic          key_push;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.address     <= IDLE_ADDR;
      bus.din         <= '0;
      bus.writeEnable <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.address     <= addr_nxt;
      bus.din         <= din_nxt;
      bus.writeEnable <= we_nxt;
    end
  end

  // The CPU normally wins, but a pending poll goes first whenever the
  // previous transaction belonged to the CPU, so a busy CPU cannot starve it.
  always_comb begin
    state_nxt = state;
    addr_nxt  = bus.address;
    din_nxt   = bus.din;
    we_nxt    = 1'b0;
    sel_cpu   = 1'b0;
    sel_poll  = 1'b0;
    capture   = 1'b0;
    cpu_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        addr_nxt = IDLE_ADDR;
        din_nxt  = '0;
        if (cpu_req && !(poll_pend && last_cpu)) begin
          sel_cpu   = 1'b1;
          cpu_ready = 1'b1;
          state_nxt = ST_ISSUE;
          addr_nxt  = cpu_addr;
          din_nxt   = cpu_wdata;
          we_nxt    = cpu_we;
        end else if (poll_pend) begin
          sel_poll  = 1'b1;
          state_nxt = ST_ISSUE;
          addr_nxt  = KEY_ADDR;
        end
      end
      ST_ISSUE: begin
        if (bus.writeEnable) begin
          state_nxt = ST_IDLE;
          addr_nxt  = IDLE_ADDR;
          din_nxt   = '0;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        capture   = 1'b1;
        state_nxt = ST_IDLE;
        addr_nxt  = IDLE_ADDR;
        din_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = IDLE_ADDR;
        din_nxt   = '0;
      end
    endcase
  end

  assign poll_wrap = (poll_cnt == CW'(POLL_PERIOD - 1));
  assign poll_cap  = capture && !owner_cpu;
  assign key_push  = poll_cap && key_is_new(bus.dout, last_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_cpu    <= 1'b0;
      last_cpu     <= 1'b0;
      cpu_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
      poll_cnt     <= '0;
      poll_pend    <= 1'b0;
      last_key     <= '0;
      key_overflow <= 1'b0;
    end else begin
      if (sel_cpu || sel_poll) begin
        owner_cpu <= sel_cpu;
        last_cpu  <= sel_cpu;
      end
      cpu_rvalid <= capture && owner_cpu;
      if (capture && owner_cpu) cpu_rdata <= bus.dout;
      poll_cnt <= poll_wrap ? '0 : poll_cnt + CW'(1);
      // A fresh wrap outranks the clear from a poll starting the same cycle.
      if (poll_wrap)     poll_pend <= 1'b1;
      else if (sel_poll) poll_pend <= 1'b0;
      if (poll_cap) last_key <= bus.dout;
      if (key_push && fifo_full && !key_pop) key_overflow <= 1'b1;
      else if (key_clear)                    key_overflow <= 1'b0;
    end
  end

  periph_bus_master_key_fifo #(.DEPTH(KEY_FIFO_DEPTH)) u_key_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (key_push),
    .push_data (bus.dout),
    .pop       (key_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (key_data)
  );

  assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_periph_bus_master.sv
module tb_periph_bus_master;

  localparam int P = 16;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = 4'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        key_pop = 1'b0;
  logic        key_overflow;
  logic        key_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  periph_bus_master_if bus ();

  periph_bus_master #(.POLL_PERIOD(P), .KEY_FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .key_pop      (key_pop),
    .key_overflow (key_overflow),
    .key_clear    (key_clear),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Slave: keypad at 0, display register at 4, registered read data.
  logic [7:0]  key_val = 8'h00;
  logic [31:0] disp = 32'h0;
  always @(posedge clk) begin
    if (bus.writeEnable && bus.address == 4'h4) disp <= bus.din;
    case (bus.address)
      4'h0:    bus.dout <= key_val;
      4'h4:    bus.dout <= disp[7:0];
      default: bus.dout <= {4'hA, bus.address};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction is free (age 0), or k cycles into
  // its bus cycle. Rules come straight from the bus protocol description.
  int         m_cnt;
  bit         m_pend;
  bit         m_last_cpu;
  int         m_age;
  bit         m_own_cpu;
  bit         m_we;
  logic [3:0] m_addr;
  logic [31:0] m_wdata;
  logic [7:0] m_q[$];
  logic [7:0] m_last_key;
  bit         m_ovf;
  bit         m_rvalid;
  logic [7:0] m_rdata;

  always @(posedge clk or posedge rst) begin : model
    bit wrap;
    bit clr;
    bit cap;
    bit pop_ok;
    bit ovf_set;
    int pre;
    logic [7:0] code;
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_last_cpu = 0; m_age = 0; m_own_cpu = 0; m_we = 0;
      m_addr = 4'hF; m_wdata = 0; m_q.delete(); m_last_key = 0; m_ovf = 0;
      m_rvalid = 0; m_rdata = 0;
    end else begin
      clr = 0; cap = 0; code = 0; m_rvalid = 0;
      if (m_age == 2) begin
        if (m_own_cpu) begin m_rvalid = 1; m_rdata = bus.dout; end
        else begin cap = 1; code = bus.dout; end
        m_age = 0;
      end else if (m_age == 1) begin
        m_age = m_we ? 0 : 2;
      end else if (cpu_req && !(m_pend && m_last_cpu)) begin
        m_age = 1; m_own_cpu = 1; m_last_cpu = 1;
        m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
      end else if (m_pend) begin
        m_age = 1; m_own_cpu = 0; m_last_cpu = 0;
        m_we = 0; m_addr = 4'h0; m_wdata = 0; clr = 1;
      end
      wrap = (m_cnt == P - 1);
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (wrap) m_pend = 1; else if (clr) m_pend = 0;
      pre = m_q.size();
      pop_ok = key_pop && pre > 0;
      if (pop_ok) void'(m_q.pop_front());
      ovf_set = 0;
      if (cap) begin
        if (code != 0 && code != m_last_key) begin
          if (pre < D || pop_ok) m_q.push_back(code);
          else ovf_set = 1;
        end
        m_last_key = code;
      end
      if (ovf_set) m_ovf = 1; else if (key_clear) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("address", bus.address, (m_age == 0) ? 4'hF : m_addr);
      chk("writeEnable", bus.writeEnable, (m_age == 1) && m_we);
      if (m_age != 2) chk("din", bus.din, (m_age == 1) ? m_wdata : 32'h0);
      chk("cpu_ready", cpu_ready, (m_age == 0) && cpu_req && !(m_pend && m_last_cpu));
      chk("cpu_rvalid", cpu_rvalid, m_rvalid);
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("key_valid", key_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("key_data", key_data, m_q[0]);
      chk("key_overflow", key_overflow, m_ovf);
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1; cpu_req = 0; key_pop = 0; key_clear = 0;
    #1;
    chk("rst_address", bus.address, 4'hF);
    chk("rst_we", bus.writeEnable, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_overflow", key_overflow, 0);
    @(negedge clk) rst = 0;
  endtask

  task automatic cpu_do(input bit we, input logic [3:0] a, input logic [31:0] wd);
    bit seen;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk); #1;
      if (cpu_ready) seen = 1;
    end
    chk("cpu_accept", seen, 1);
    @(posedge clk); #1;
    cpu_req = 0;
  endtask

  task automatic wait_poll();
    bit on;
    bit off;
    on = 0; off = 0;
    for (int n = 0; n < 200 && !on; n++) begin
      @(negedge clk); #1;
      if (bus.address == 4'h0) on = 1;
    end
    for (int n = 0; n < 10 && on && !off; n++) begin
      @(negedge clk); #1;
      if (bus.address != 4'h0) off = 1;
    end
    chk("poll_seen", on && off, 1);
  endtask

  task automatic pop_key();
    @(posedge clk); #1; key_pop = 1;
    @(posedge clk); #1; key_pop = 0;
    @(negedge clk); #1;
  endtask

  logic [7:0] seq_a[5] = '{8'h00, 8'h31, 8'h31, 8'h00, 8'h31};
  logic [7:0] seq_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    int k;
    bit rv_seen;
    bit rdy;
    int polls;
    int cpus;
    int doubles;
    bit last_poll;
    logic [3:0] prev_addr;

    #3;
    do_reset();

    // Write: one strobe cycle with address/data.
    cpu_do(1, 4'h4, 32'h1234_5678);
    @(negedge clk); #1;
    chk("wr_we", bus.writeEnable, 1);
    chk("wr_addr", bus.address, 4'h4);
    chk("wr_din", bus.din, 32'h1234_5678);
    @(negedge clk); #1;
    chk("wr_we_end", bus.writeEnable, 0);
    chk("wr_addr_end", bus.address, 4'hF);

    // Read: rvalid three cycles after the accept cycle.
    key_val = 8'h3A;
    cpu_do(0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rd_rvalid", cpu_rvalid, (i == 2));
    end
    chk("rd_rdata", cpu_rdata, 8'h3A);

    // Poll edge detection: only presses after a release (or first) queue.
    key_val = 8'h00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      key_val = seq_a[i];
      wait_poll();
    end
    @(negedge clk); #1;
    chk("poll_valid0", key_valid, 1);
    chk("poll_data0", key_data, 8'h31);
    pop_key();
    chk("poll_valid1", key_valid, 1);
    chk("poll_data1", key_data, 8'h31);
    pop_key();
    chk("poll_valid2", key_valid, 0);

    // Overflow: five distinct keys into a four-entry queue.
    key_val = 8'h00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      key_val = seq_b[i];
      wait_poll();
    end
    @(negedge clk); #1;
    chk("ovf_flag", key_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_valid", key_valid, 1);
      chk("ovf_data", key_data, seq_b[i]);
      pop_key();
    end
    chk("ovf_empty", key_valid, 0);
    @(posedge clk); #1; key_clear = 1;
    @(posedge clk); #1; key_clear = 0;
    @(negedge clk); #1;
    chk("ovf_cleared", key_overflow, 0);

    // Contention: CPU holds a request continuously.
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'h4; cpu_wdata = 32'hCAFE_0001;
    polls = 0; cpus = 0; doubles = 0; last_poll = 0; prev_addr = 4'hF;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (prev_addr == 4'hF && bus.address != 4'hF) begin
        if (bus.address == 4'h0) begin
          if (last_poll) doubles++;
          polls++; last_poll = 1;
        end else begin
          cpus++; last_poll = 0;
        end
      end
      prev_addr = bus.address;
    end
    @(posedge clk); #1; cpu_req = 0;
    chk("cont_polls_ge11", polls >= 11, 1);
    chk("cont_no_double_poll", doubles, 0);
    chk("cont_cpu_progress", cpus > polls, 1);

    // Reset during the read wait cycle.
    do_reset();
    key_val = 8'h00;
    cpu_do(0, 4'h0, 32'h0);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("rstw_address", bus.address, 4'hF);
    chk("rstw_we", bus.writeEnable, 0);
    chk("rstw_rvalid", cpu_rvalid, 0);
    chk("rstw_key_valid", key_valid, 0);
    @(negedge clk) rst = 0;
    k = 0; rv_seen = 0;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      @(negedge clk); #1;
      if (cpu_rvalid) rv_seen = 1;
      if (bus.address == 4'h0) k = n;
    end
    chk("rstw_poll_restart", k, P + 1);
    chk("rstw_no_rvalid", rv_seen, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      rdy = cpu_ready;
      @(posedge clk); #1;
      if (cpu_req && rdy) cpu_req = 0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1;
        cpu_we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: cpu_addr = 4'h0;
          1: cpu_addr = 4'h4;
          default: cpu_addr = 4'($urandom);
        endcase
        cpu_wdata = $urandom;
      end
      key_pop = (c < 700) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      key_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: key_val = 8'h00;
          1: key_val = 8'h31;
          2: key_val = 8'h42;
          default: key_val = 8'($urandom);
        endcase
      end
    end
    @(posedge clk); #1;
    cpu_req = 0; key_pop = 0; key_clear = 0;
    repeat (5) @(negedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
